// File: rtl/odd_par_pkg.sv
// Shared definitions for the odd-parity frame transmitter: frame sizing
// helpers, the fill-frame constant, the frame-source selector and the
// odd-parity function.
package odd_par_pkg;

  // Largest legal data width. Helpers are sized to it and narrower users
  // zero-extend, which leaves parity unchanged.
  localparam int MAX_DATA_BITS = 7;
  localparam int MAX_FRAME     = MAX_DATA_BITS + 1;

  // The fill frame is all-zero data followed by a parity bit of 1. For any
  // frame length this is the value 1, truncated to FRAME bits.
  localparam logic [MAX_FRAME-1:0] FILL_FRAME = MAX_FRAME'(1);

  // Source of the next frame, chosen at each frame boundary.
  typedef enum logic [1:0] {
    SEL_BUF    = 2'd0,  // word waiting in the holding buffer
    SEL_BYPASS = 2'd1,  // word accepted on the boundary edge itself
    SEL_FILL   = 2'd2   // nothing to send: keep the line framed
  } frame_sel_e;

  // Frame length for a given data width: data bits plus one parity bit.
  function automatic int frame_len(input int data_bits);
    return data_bits + 1;
  endfunction

  // Width of the bit counter inside a frame, never less than one bit.
  function automatic int cnt_width(input int data_bits);
    int w;
    w = $clog2(data_bits + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Parity bit that makes the total number of ones in {data, p} odd.
  function automatic logic odd_parity(input logic [MAX_DATA_BITS-1:0] data);
    return ~^data;
  endfunction

endpackage : odd_par_pkg

// File: rtl/odd_par_frame_shift.sv
// Frame shift register and bit counter. Shifts the current frame out MSB
// first; on the last bit of a frame it loads the next frame presented on
// load_val_i and restarts the count. Comes out of reset holding a fill frame
// with bit 0 already on the line.
module odd_par_frame_shift
  import odd_par_pkg::*;
#(
  parameter int DATA_BITS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_BITS:0] load_val_i,
  output logic               x_o,
  output logic               frame_start_o,
  output logic               boundary_o
);

  localparam int FRAME = frame_len(DATA_BITS);
  localparam int CW    = cnt_width(DATA_BITS);
  localparam logic [CW-1:0]      LAST_BIT  = CW'(FRAME - 1);
  localparam logic [DATA_BITS:0] FILL_INIT = FILL_FRAME[DATA_BITS:0];

  logic [DATA_BITS:0] sreg_q, sreg_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  // The line comes straight off the top register bit, so it is glitch-free.
  assign x_o           = sreg_q[DATA_BITS];
  assign frame_start_o = (cnt_q == '0);
  assign boundary_o    = (cnt_q == LAST_BIT);

  // Next state: shift with zero fill inside a frame, reload at its last bit.
  // NOTE: every combinational output is given a default before any branch so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    sreg_d = {sreg_q[DATA_BITS-1:0], 1'b0};
    cnt_d  = cnt_q + CW'(1);
    if (boundary_o) begin
      sreg_d = load_val_i;
      cnt_d  = '0;
    end
  end

  // State register; reset parks the line on bit 0 of a fill frame.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q <= FILL_INIT;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule : odd_par_frame_shift

// File: rtl/odd_par_frame_tx.sv
// Serial transmitter for the odd-parity frame protocol. Takes parallel words
// over a valid/ready handshake, holds at most one in a buffer, and sends each
// as {data, parity} MSB first. When nothing is pending it sends fill frames so
// the receiver stays frame-aligned.
//
// Build option: define ODD_PAR_TX_ERR_INJ_EN to add the inj_err input, which
// inverts the parity bit of the frame loaded on a boundary edge (fill frames
// included), giving deliberately bad frames to exercise the checker.
module odd_par_frame_tx
  import odd_par_pkg::*;
#(
  parameter int DATA_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef ODD_PAR_TX_ERR_INJ_EN
  input  logic                 inj_err,
`endif
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 x_out,
  output logic                 frame_start,
  output logic                 fill_out,
  output logic                 busy
);

  localparam logic [DATA_BITS:0] FILL = FILL_FRAME[DATA_BITS:0];

  logic [DATA_BITS-1:0] buf_q, buf_d;
  logic                 buf_valid_q, buf_valid_d;
  logic                 cur_fill_q, cur_fill_d;

  logic                 accept;
  logic                 boundary;
  logic                 inj_w;
  frame_sel_e           frame_sel;
  logic [DATA_BITS:0]   load_val;

`ifdef ODD_PAR_TX_ERR_INJ_EN
  assign inj_w = inj_err;
`else
  assign inj_w = 1'b0;
`endif

  // Ready is the registered buffer state, never a function of tx_valid.
  assign tx_ready = ~buf_valid_q;
  assign accept   = tx_valid & ~buf_valid_q;
  assign fill_out = cur_fill_q;
  assign busy     = ~cur_fill_q | buf_valid_q;

  // Pick the next frame: buffered word first, then a word arriving on the
  // boundary edge itself, otherwise a fill frame.
  always_comb begin
    frame_sel = SEL_FILL;
    load_val  = FILL;
    if (buf_valid_q) begin
      frame_sel = SEL_BUF;
    end else if (accept) begin
      frame_sel = SEL_BYPASS;
    end
    case (frame_sel)
      SEL_BUF:    load_val = {buf_q, odd_parity(MAX_DATA_BITS'(buf_q))};
      SEL_BYPASS: load_val = {tx_data, odd_parity(MAX_DATA_BITS'(tx_data))};
      default:    load_val = FILL;
    endcase
    load_val[0] = load_val[0] ^ inj_w;
  end

  // Buffer and frame-type bookkeeping. A boundary always empties the buffer:
  // either its word moves into the shifter, or it was empty and an accept on
  // this edge bypasses straight into the shifter.
  always_comb begin
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    cur_fill_d  = cur_fill_q;
    if (boundary) begin
      buf_valid_d = 1'b0;
      cur_fill_d  = (frame_sel == SEL_FILL);
    end else if (accept) begin
      buf_d       = tx_data;
      buf_valid_d = 1'b1;
    end
  end

  // Control flags; reset drops any buffered word and marks the frame as fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      cur_fill_q  <= 1'b1;
    end else begin
      buf_valid_q <= buf_valid_d;
      cur_fill_q  <= cur_fill_d;
    end
  end

  // Buffer payload register.
  // NOTE: the payload has no reset; it is only read while buf_valid_q is set,
  // so clearing the valid flag is enough and the data flops stay cheaper.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  odd_par_frame_shift #(
    .DATA_BITS (DATA_BITS)
  ) u_shift (
    .clk           (clk),
    .rst           (rst),
    .load_val_i    (load_val),
    .x_o           (x_out),
    .frame_start_o (frame_start),
    .boundary_o    (boundary)
  );

endmodule : odd_par_frame_tx
